// File: rtl/divider_pkg.sv
// Shared definitions for the signed divider and its BCD readout stage.
package divider_pkg;
  localparam int         WIDTH_DEF  = 8;
  localparam int         DIGITS_DEF = 3;
  localparam int         CNT_W_DEF  = $clog2(WIDTH_DEF);
  localparam logic [3:0] DAB_THRESH = 4'd5;
  localparam logic [3:0] DAB_CORR   = 4'd3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_LOW} state_t;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= DAB_THRESH) ? n + DAB_CORR : n;
  endfunction
endpackage

// File: rtl/signed_bcd_module_if.sv
// Start/Done handshake plus operand and result buses of the signed BCD converter.
interface signed_bcd_module_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  Start_Sig;
  logic [WIDTH-1:0]      Quotient;
  logic [WIDTH-1:0]      Reminder;
  logic                  Done_Sig;
  logic                  Q_Sign;
  logic [4*DIGITS-1:0]   Q_Bcd;
  logic                  R_Sign;
  logic [4*DIGITS-1:0]   R_Bcd;

  modport master (
    output Start_Sig, Quotient, Reminder,
    input  Done_Sig, Q_Sign, Q_Bcd, R_Sign, R_Bcd
  );
  modport slave (
    input  Start_Sig, Quotient, Reminder,
    output Done_Sig, Q_Sign, Q_Bcd, R_Sign, R_Bcd
  );
endinterface

// File: rtl/signed_bcd_module_dabble_core.sv
// One double-dabble lane: captures |operand|, then shifts one bit per enabled clock.
module bcd_dabble_core
  import divider_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [WIDTH-1:0]    operand,
  output logic [4*DIGITS-1:0] bcd_next
);
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_nib
    assign adj[4*d +: 4] = dabble(bcd[4*d +: 4]);
  end

  // Exposed combinationally so the parent can load the result on the final shift edge.
  assign bcd_next = {adj[4*DIGITS-2:0], mag[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
      bcd <= '0;
    end else if (load) begin
      mag <= operand[WIDTH-1] ? (~operand + 1'b1) : operand;
      bcd <= '0;
    end else if (shift) begin
      bcd <= bcd_next;
      mag <= {mag[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/signed_bcd_module.sv
// Converts the divider's signed quotient/remainder to sign + BCD magnitude, one bit per clock.
module signed_bcd_module
  import divider_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  signed_bcd_module_if.slave bus
);
  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                load, shift, finish;
  logic                q_sgn, r_sgn;
  logic [4*DIGITS-1:0] q_nx, r_nx;
  logic                done_r, q_sign_r, r_sign_r;
  logic [4*DIGITS-1:0] q_bcd_r, r_bcd_r;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:
        if (bus.Start_Sig) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      // A master still holding Start here has not yet reacted to Done; park until it lets go.
      DONE:     state_nx = bus.Start_Sig ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!bus.Start_Sig) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      q_sgn <= 1'b0;
      r_sgn <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      q_sgn <= bus.Quotient[WIDTH-1];
      r_sgn <= bus.Reminder[WIDTH-1];
    end else if (shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  bcd_dabble_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q (
    .clk(CLK), .rst(RST), .load(load), .shift(shift),
    .operand(bus.Quotient), .bcd_next(q_nx)
  );

  bcd_dabble_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r (
    .clk(CLK), .rst(RST), .load(load), .shift(shift),
    .operand(bus.Reminder), .bcd_next(r_nx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_r   <= 1'b0;
      q_sign_r <= 1'b0;
      r_sign_r <= 1'b0;
      q_bcd_r  <= '0;
      r_bcd_r  <= '0;
    end else begin
      done_r <= finish;
      if (finish) begin
        q_sign_r <= q_sgn;
        r_sign_r <= r_sgn;
        q_bcd_r  <= q_nx;
        r_bcd_r  <= r_nx;
      end
    end
  end

  assign bus.Done_Sig = done_r;
  assign bus.Q_Sign   = q_sign_r;
  assign bus.R_Sign   = r_sign_r;
  assign bus.Q_Bcd    = q_bcd_r;
  assign bus.R_Bcd    = r_bcd_r;
endmodule

// File: tb/tb_signed_bcd_module.sv
// Directed-vector bench for signed_bcd_module with hand-computed BCD results.
module tb_signed_bcd_module;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   lat;
  int   p0;

  signed_bcd_module_if #(.WIDTH(8), .DIGITS(3)) bus ();
  signed_bcd_module #(.WIDTH(8), .DIGITS(3)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.Done_Sig) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic qs, input logic [11:0] qb,
                         input logic rs, input logic [11:0] rb);
    chk({tag, ".q_sign"}, bus.Q_Sign, qs);
    chk({tag, ".q_bcd"},  bus.Q_Bcd,  qb);
    chk({tag, ".r_sign"}, bus.R_Sign, rs);
    chk({tag, ".r_bcd"},  bus.R_Bcd,  rb);
  endtask

  // mode 0: drop Start on seeing Done; 1: drop one edge later; 2: drop and scramble operands mid-shift
  task automatic run_conv(input logic [7:0] q, input logic [7:0] r, input int mode, output int l);
    @(negedge clk);
    bus.Quotient = q; bus.Reminder = r; bus.Start_Sig = 1'b1;
    @(posedge clk);
    l = 0;
    do begin
      @(posedge clk); #1; l++;
      if (mode == 2 && l == 2) begin
        bus.Quotient = 8'h11; bus.Reminder = 8'h22; bus.Start_Sig = 1'b0;
      end
    end while (!bus.Done_Sig && l < 40);
    if (mode != 1) bus.Start_Sig = 1'b0;
    @(posedge clk); #1;
    chk("done_width", bus.Done_Sig, 1'b0);
    bus.Start_Sig = 1'b0;
  endtask

  initial begin
    bus.Start_Sig = 1'b0; bus.Quotient = '0; bus.Reminder = '0;
    #12;
    chk("rst.done", bus.Done_Sig, 1'b0);
    chk_out("rst", 1'b0, 12'h000, 1'b0, 12'h000);
    @(negedge clk) rst = 1'b0;

    run_conv(8'h01, 8'h03, 0, lat);
    chk("t1.lat", lat, 8);
    chk_out("t1", 1'b0, 12'h001, 1'b0, 12'h003);

    run_conv(8'hFF, 8'hFD, 0, lat);
    chk_out("t2", 1'b1, 12'h001, 1'b1, 12'h003);

    run_conv(8'h80, 8'h7F, 0, lat);
    chk_out("t3a", 1'b1, 12'h128, 1'b0, 12'h127);
    run_conv(8'h00, 8'hF6, 0, lat);
    chk_out("t3b", 1'b0, 12'h000, 1'b1, 12'h010);

    p0 = pulses;
    run_conv(8'h2A, 8'h07, 1, lat);
    chk_out("t4a", 1'b0, 12'h042, 1'b0, 12'h007);
    repeat (2) @(negedge clk);
    run_conv(8'h9C, 8'h05, 0, lat);
    chk_out("t4b", 1'b1, 12'h100, 1'b0, 12'h005);
    repeat (3) @(negedge clk);
    chk("t4.pulses", pulses - p0, 2);

    p0 = pulses;
    @(negedge clk);
    bus.Quotient = 8'hE7; bus.Reminder = 8'h0C; bus.Start_Sig = 1'b1;
    repeat (30) @(negedge clk);
    bus.Start_Sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4.held_pulses", pulses - p0, 1);
    chk_out("t4c", 1'b1, 12'h025, 1'b0, 12'h012);

    p0 = pulses;
    @(negedge clk);
    bus.Quotient = 8'hC9; bus.Reminder = 8'h2A; bus.Start_Sig = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5.done", bus.Done_Sig, 1'b0);
    chk_out("t5.rst", 1'b0, 12'h000, 1'b0, 12'h000);
    @(negedge clk) bus.Start_Sig = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5.no_pulse", pulses - p0, 0);
    run_conv(8'hC9, 8'h2A, 0, lat);
    chk("t5.lat", lat, 8);
    chk_out("t5", 1'b1, 12'h055, 1'b0, 12'h042);

    p0 = pulses;
    run_conv(8'h85, 8'hFE, 2, lat);
    chk("t6.lat", lat, 8);
    chk_out("t6", 1'b1, 12'h123, 1'b1, 12'h002);
    repeat (3) @(negedge clk);
    chk("t6.pulses", pulses - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/signed_bcd_module.md
Name: signed_bcd_module

Overview:
- Downstream consumer of the signed 8-bit divider.
- Takes the divider's two's-complement Quotient and Reminder and converts each to a sign flag plus a 3-digit BCD magnitude for the display/readout stage.
- Uses the same Start_Sig/Done_Sig handshake as the divider.
- Conversion is iterative shift-add-3 (double dabble), one bit per clock, with both operands processed in parallel.

Parameters:
- WIDTH, 8: operand width in bits (two's complement).
- DIGITS, 3: BCD digits per magnitude. Must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start_Sig  in  1  request. Master holds it high until it sees Done_Sig, then drops it.
- Quotient  in  WIDTH  signed quotient from the divider.
- Reminder  in  WIDTH  signed remainder from the divider.
- Done_Sig  out  1  one-cycle completion pulse.
- Q_Sign  out  1  1 = quotient negative.
- Q_Bcd  out  4*DIGITS  BCD magnitude of the quotient, hundreds digit in the top nibble.
- R_Sign  out  1  1 = remainder negative.
- R_Bcd  out  4*DIGITS  BCD magnitude of the remainder.

Behaviour:
- Reset: one clock, CLK. Reset is asynchronous and active-high, port RST. Asserting RST forces state IDLE and clears Done_Sig, Q_Sign, R_Sign, Q_Bcd, R_Bcd and all internal registers to 0, from any state.
- IDLE
  - Start_Sig=1 at edge C captures both operands.
  - Sign = operand MSB.
  - Magnitude = operand, or its two's-complement negation if negative, held as WIDTH unsigned bits. -128 gives 128, with no overflow.
  - Clears the BCD accumulators and the bit counter; next state SHIFT.
- SHIFT (WIDTH cycles, edges C+1..C+WIDTH)
  - Before each shift, add 3 to every BCD nibble that is >=5.
  - Then shift {bcd, mag} left by 1.
  - Counter increments. When the counter reaches WIDTH-1, next state DONE.
- DONE
  - At edge C+WIDTH, the final BCD values and signs load into the output registers.
  - Done_Sig=1 for exactly the cycle C+WIDTH..C+WIDTH+1. For WIDTH=8, capture-to-Done latency is 8 clocks.
  - Next edge: Done_Sig goes to 0. Next state is WAIT_LOW if Start_Sig=1, else IDLE.
- WAIT_LOW
  - Stays until Start_Sig=0, then goes to IDLE.
  - Prevents a second conversion when the master drops Start_Sig on the same edge it samples Done_Sig.
- Output timing: outputs change only at the DONE-load edge and hold until the next DONE-load or reset. Intermediate shift values are never visible on the outputs.
- Start_Sig deasserted during SHIFT: ignored; the conversion completes and Done_Sig still pulses.
- Operand changes after capture: ignored.
- Zero operand: sign 0, BCD all zeros. There is no negative zero.
- Start_Sig=1 continuously: exactly one conversion per rising of Start_Sig out of WAIT_LOW/IDLE.

Decomposition:
- Shared package (divider_pkg):
  - State encodings IDLE/SHIFT/DONE/WAIT_LOW.
  - Default WIDTH=8, DIGITS=3.
  - Dabble threshold 4'd5 and correction 4'd3.
  - Counter width clog2(WIDTH).
- One sub-module, bcd_dabble_core, instantiated twice (quotient, remainder). It contains:
  - Magnitude/BCD shift register.
  - Per-nibble add-3 logic.
  - load/shift enables from the parent FSM.
- The parent owns the FSM, the counter, the sign capture and the output registers.

Test Plan:
1. Quotient=8'd1, Reminder=8'd3 (from 9/6), Start_Sig held until Done -> Done_Sig pulses 8 clocks after capture; Q_Sign=0 Q_Bcd=12'h001, R_Sign=0 R_Bcd=12'h003.
2. Quotient=8'hFF, Reminder=8'hFD (-1, -3) -> Q_Sign=1 Q_Bcd=12'h001, R_Sign=1 R_Bcd=12'h003.
3. Quotient=8'h80, Reminder=8'h7F -> Q_Sign=1 Q_Bcd=12'h128, R_Sign=0 R_Bcd=12'h127; Quotient=8'h00 -> Q_Sign=0 Q_Bcd=12'h000.
4. Master drops Start_Sig on the edge it sees Done, then reasserts two cycles later with 8'h9C / 8'h05 -> exactly two Done pulses; second result Q_Sign=1 Q_Bcd=12'h100, R_Bcd=12'h005. If Start_Sig is held high for 30 cycles -> only one Done pulse.
5. RST=1 asynchronously at SHIFT cycle 4 -> all outputs 0 immediately, no Done_Sig. After release, a new request completes with correct values and the full 8-clock latency.
6. Change Quotient/Reminder and drop Start_Sig during SHIFT -> results reflect the values captured at edge C; Done_Sig still pulses once.
